// File: rtl/relu_maxpool_pkg.sv
// relu_maxpool_pkg: shared definitions for the ReLU + 2x2 max-pool stage.
//   - FSM state encoding (IDLE, FETCH, POOL, FLUSH, DONE)
//   - map geometry (IMG_DIM, OUT_WORDS and derived sizes)
//   - byte-lane helpers shared with the convolution stage; lane 0 is [31:24]
//   - wr_t: payload of one packed output write (byte enables, address, data)
package relu_maxpool_pkg;

    localparam int unsigned IMG_DIM    = 26;
    localparam int unsigned OUT_DIM    = IMG_DIM / 2;
    localparam int unsigned OUT_WORDS  = (OUT_DIM * OUT_DIM + 3) / 4;
    localparam int unsigned ROW_WORDS  = (2 * IMG_DIM) / 4;
    localparam int unsigned PAIR_BYTES = 2 * IMG_DIM;
    localparam int unsigned PIX_W      = 8;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned BE_W       = DATA_W / PIX_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_POOL,
        ST_FLUSH,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    // Extract the pixel held in a lane (lane 0 = lowest byte index = [31:24]).
    function automatic logic [PIX_W-1:0] lane_byte(input logic [DATA_W-1:0] word,
                                                   input logic [1:0] lane);
        case (lane)
            2'd0:    return word[31:24];
            2'd1:    return word[23:16];
            2'd2:    return word[15:8];
            default: return word[7:0];
        endcase
    endfunction

    // Return word with one lane replaced by pix.
    function automatic logic [DATA_W-1:0] pack_lane(input logic [DATA_W-1:0] word,
                                                    input logic [1:0] lane,
                                                    input logic [PIX_W-1:0] pix);
        logic [DATA_W-1:0] w;
        w = word;
        case (lane)
            2'd0:    w[31:24] = pix;
            2'd1:    w[23:16] = pix;
            2'd2:    w[15:8]  = pix;
            default: w[7:0]   = pix;
        endcase
        return w;
    endfunction

    // Byte enables for a partial word holding 'filled' lanes from lane 0 up.
    function automatic logic [BE_W-1:0] fill_mask(input logic [1:0] filled);
        case (filled)
            2'd1:    return 4'b1000;
            2'd2:    return 4'b1100;
            2'd3:    return 4'b1110;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/relu_maxpool_max4_relu.sv
// relu_maxpool_max4_relu: combinational signed max of four 8-bit pixels.
//   a, b, c, d : candidate pixels (two's complement)
//   max_c      : signed max; clamped at 0 when POOL_RELU_EN is defined
// Macro: POOL_RELU_EN enables the ReLU clamp.
module relu_maxpool_max4_relu
    import relu_maxpool_pkg::*;
(
    input  logic [PIX_W-1:0] a,
    input  logic [PIX_W-1:0] b,
    input  logic [PIX_W-1:0] c,
    input  logic [PIX_W-1:0] d,
    output logic [PIX_W-1:0] max_c
);

    logic signed [PIX_W-1:0] m_ab;
    logic signed [PIX_W-1:0] m_cd;
    logic signed [PIX_W-1:0] m_all;

    // Two-level signed compare tree.
    always_comb begin
        m_ab  = ($signed(a) > $signed(b)) ? $signed(a) : $signed(b);
        m_cd  = ($signed(c) > $signed(d)) ? $signed(c) : $signed(d);
        m_all = (m_ab > m_cd) ? m_ab : m_cd;
`ifdef POOL_RELU_EN
        max_c = m_all[PIX_W-1] ? '0 : m_all;
`else
        max_c = m_all;
`endif
    end

endmodule

// File: rtl/relu_maxpool.sv
// relu_maxpool: ReLU + 2x2/stride-2 max pooling of two 26x26 int8 maps.
//   clk, rst            : clock, asynchronous active-low reset
//   start / finish      : level start in IDLE; finish held in DONE until start drops
//   M1_*/M2_*           : read ports (req, word address, data one cycle after req)
//   M3_*/M4_*           : write ports (byte enables, word address, packed data)
// Channels 0 (M1->M3) and 1 (M2->M4) run in lockstep.
// Macro: POOL_RELU_EN selects the clamp in relu_maxpool_max4_relu.
module relu_maxpool
    import relu_maxpool_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              finish,
    output logic              M1_R_req,
    output logic [ADDR_W-1:0] M1_addr,
    input  logic [DATA_W-1:0] M1_R_data,
    output logic              M2_R_req,
    output logic [ADDR_W-1:0] M2_addr,
    input  logic [DATA_W-1:0] M2_R_data,
    output logic [BE_W-1:0]   M3_W_req,
    output logic [ADDR_W-1:0] M3_addr,
    output logic [DATA_W-1:0] M3_W_data,
    output logic [BE_W-1:0]   M4_W_req,
    output logic [ADDR_W-1:0] M4_addr,
    output logic [DATA_W-1:0] M4_W_data
);

    state_t            state;
    logic [3:0]        k_cnt;       // fetch cycle within a row pair (0..13)
    logic [3:0]        col;         // pooled column (0..12)
    logic [3:0]        row;         // pooled row (0..12)
    logic [7:0]        row_base;    // first word of the current row pair
    logic [7:0]        out_cnt;     // output byte counter across the whole map
    logic              cap_valid;   // read data present this cycle
    logic [3:0]        cap_idx;     // pair-buffer word the data belongs to
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] pack0;
    logic [DATA_W-1:0] pack1;
    wr_t               wr0;
    wr_t               wr1;

    // Pair buffers: bytes 0..25 are row 2r, 26..51 are row 2r+1.
    logic [PIX_W-1:0]  pair0 [PAIR_BYTES];
    logic [PIX_W-1:0]  pair1 [PAIR_BYTES];

    logic [5:0]        idx_base;
    logic [PIX_W-1:0]  win0 [4];
    logic [PIX_W-1:0]  win1 [4];
    logic [PIX_W-1:0]  pool0_c;
    logic [PIX_W-1:0]  pool1_c;

    // Capture returning read data; fully rewritten each row before use.
    always_ff @(posedge clk) begin
        if (cap_valid) begin
            for (int i = 0; i < 4; i++) begin
                pair0[{cap_idx, 2'(i)}] <= lane_byte(M1_R_data, 2'(i));
                pair1[{cap_idx, 2'(i)}] <= lane_byte(M2_R_data, 2'(i));
            end
        end
    end

    // 2x2 window for the current column.
    always_comb begin
        idx_base = {1'b0, col, 1'b0};
        win0[0]  = pair0[idx_base];
        win0[1]  = pair0[idx_base + 6'd1];
        win0[2]  = pair0[idx_base + 6'(IMG_DIM)];
        win0[3]  = pair0[idx_base + 6'(IMG_DIM + 1)];
        win1[0]  = pair1[idx_base];
        win1[1]  = pair1[idx_base + 6'd1];
        win1[2]  = pair1[idx_base + 6'(IMG_DIM)];
        win1[3]  = pair1[idx_base + 6'(IMG_DIM + 1)];
    end

    relu_maxpool_max4_relu u_max0 (
        .a     (win0[0]),
        .b     (win0[1]),
        .c     (win0[2]),
        .d     (win0[3]),
        .max_c (pool0_c)
    );

    relu_maxpool_max4_relu u_max1 (
        .a     (win1[0]),
        .b     (win1[1]),
        .c     (win1[2]),
        .d     (win1[3]),
        .max_c (pool1_c)
    );

    // Control FSM, read sequencer and output packers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            k_cnt     <= '0;
            col       <= '0;
            row       <= '0;
            row_base  <= '0;
            out_cnt   <= '0;
            cap_valid <= 1'b0;
            cap_idx   <= '0;
            rd_req    <= 1'b0;
            rd_addr   <= '0;
            pack0     <= '0;
            pack1     <= '0;
            wr0       <= '0;
            wr1       <= '0;
            finish    <= 1'b0;
        end else begin
            rd_req    <= 1'b0;
            rd_addr   <= '0;
            wr0.be    <= '0;
            wr1.be    <= '0;
            // Data for the word requested this cycle arrives next cycle.
            cap_valid <= rd_req;
            cap_idx   <= k_cnt;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_FETCH;
                        k_cnt    <= '0;
                        col      <= '0;
                        row      <= '0;
                        row_base <= '0;
                        out_cnt  <= '0;
                        pack0    <= '0;
                        pack1    <= '0;
                        rd_req   <= 1'b1;
                        rd_addr  <= '0;
                    end
                end

                ST_FETCH: begin
                    if (k_cnt < 4'(ROW_WORDS - 1)) begin
                        rd_req  <= 1'b1;
                        rd_addr <= ADDR_W'(row_base) + ADDR_W'(k_cnt) + ADDR_W'(1);
                    end
                    // One extra cycle after the last request lets its data land.
                    if (k_cnt == 4'(ROW_WORDS)) begin
                        state <= ST_POOL;
                        col   <= '0;
                    end else begin
                        k_cnt <= k_cnt + 4'd1;
                    end
                end

                ST_POOL: begin
                    pack0   <= pack_lane(pack0, out_cnt[1:0], pool0_c);
                    pack1   <= pack_lane(pack1, out_cnt[1:0], pool1_c);
                    out_cnt <= out_cnt + 8'd1;
                    if (out_cnt[1:0] == 2'd3) begin
                        wr0.be   <= 4'hF;
                        wr0.addr <= ADDR_W'(out_cnt[7:2]);
                        wr0.data <= pack_lane(pack0, 2'd3, pool0_c);
                        wr1.be   <= 4'hF;
                        wr1.addr <= ADDR_W'(out_cnt[7:2]);
                        wr1.data <= pack_lane(pack1, 2'd3, pool1_c);
                        pack0    <= '0;
                        pack1    <= '0;
                    end
                    if (col == 4'(OUT_DIM - 1)) begin
                        if (row == 4'(OUT_DIM - 1)) begin
                            state <= ST_FLUSH;
                        end else begin
                            state    <= ST_FETCH;
                            row      <= row + 4'd1;
                            row_base <= row_base + 8'(ROW_WORDS);
                            k_cnt    <= '0;
                            rd_req   <= 1'b1;
                            rd_addr  <= ADDR_W'(row_base) + ADDR_W'(ROW_WORDS);
                        end
                    end else begin
                        col <= col + 4'd1;
                    end
                end

                ST_FLUSH: begin
                    if (out_cnt[1:0] != 2'd0) begin
                        wr0.be   <= fill_mask(out_cnt[1:0]);
                        wr0.addr <= ADDR_W'(out_cnt[7:2]);
                        wr0.data <= pack0;
                        wr1.be   <= fill_mask(out_cnt[1:0]);
                        wr1.addr <= ADDR_W'(out_cnt[7:2]);
                        wr1.data <= pack1;
                    end
                    state  <= ST_DONE;
                    finish <= 1'b1;
                end

                ST_DONE: begin
                    if (!start) begin
                        finish <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign M1_R_req  = rd_req;
    assign M1_addr   = rd_addr;
    assign M2_R_req  = rd_req;
    assign M2_addr   = rd_addr;
    assign M3_W_req  = wr0.be;
    assign M3_addr   = wr0.addr;
    assign M3_W_data = wr0.data;
    assign M4_W_req  = wr1.be;
    assign M4_addr   = wr1.addr;
    assign M4_W_data = wr1.data;

endmodule

// File: tb/tb_relu_maxpool.sv
// tb_relu_maxpool: scoreboard bench for relu_maxpool.
// Stimulus fills two byte images, a reference model pools them into expected
// write records; a negedge monitor checks every read address and write.
module tb_relu_maxpool;
    import relu_maxpool_pkg::*;

    localparam int unsigned IN_BYTES = IMG_DIM * IMG_DIM;
    localparam int unsigned IN_WORDS = IN_BYTES / 4;
    localparam int unsigned MAX_LAT  = 13 * (14 + 13 + 2) + 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        finish;
    logic        M1_R_req, M2_R_req;
    logic [31:0] M1_addr, M2_addr;
    logic [31:0] M1_R_data = '0;
    logic [31:0] M2_R_data = '0;
    logic [3:0]  M3_W_req, M4_W_req;
    logic [31:0] M3_addr, M4_addr, M3_W_data, M4_W_data;

    int n_checks = 0;
    int n_fail   = 0;
    int rd_exp   = 0;

    logic [7:0]  img [2][IN_BYTES];
    logic [31:0] mem1 [IN_WORDS];
    logic [31:0] mem2 [IN_WORDS];
    wr_t         q3 [$];
    wr_t         q4 [$];

    relu_maxpool dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .finish    (finish),
        .M1_R_req  (M1_R_req),
        .M1_addr   (M1_addr),
        .M1_R_data (M1_R_data),
        .M2_R_req  (M2_R_req),
        .M2_addr   (M2_addr),
        .M2_R_data (M2_R_data),
        .M3_W_req  (M3_W_req),
        .M3_addr   (M3_addr),
        .M3_W_data (M3_W_data),
        .M4_W_req  (M4_W_req),
        .M4_addr   (M4_addr),
        .M4_W_data (M4_W_data)
    );

    always #5 clk = ~clk;

    // Memories: data valid the cycle after the request.
    always @(posedge clk) begin
        if (M1_R_req && M1_addr < IN_WORDS) M1_R_data <= mem1[M1_addr[7:0]];
        if (M2_R_req && M2_addr < IN_WORDS) M2_R_data <= mem2[M2_addr[7:0]];
    end

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: reads must walk words 0..168 in order; writes pop the scoreboard.
    always @(negedge clk) begin
        if (M1_R_req || M2_R_req) begin
            check("read_addr", 72'({M1_R_req, M2_R_req, M1_addr, M2_addr}),
                  72'({1'b1, 1'b1, 32'(rd_exp), 32'(rd_exp)}));
            rd_exp++;
        end
        if (M3_W_req != 4'd0) begin
            if (q3.size() == 0) begin
                check("m3_unexpected_write", 72'({M3_W_req, M3_addr, M3_W_data}), 72'(0));
            end else begin
                wr_t e;
                e = q3.pop_front();
                check("m3_write", 72'({M3_W_req, M3_addr, M3_W_data}), 72'(e));
            end
        end
        if (M4_W_req != 4'd0) begin
            if (q4.size() == 0) begin
                check("m4_unexpected_write", 72'({M4_W_req, M4_addr, M4_W_data}), 72'(0));
            end else begin
                wr_t e;
                e = q4.pop_front();
                check("m4_write", 72'({M4_W_req, M4_addr, M4_W_data}), 72'(e));
            end
        end
    end

    // Pack the images into the read memories, lowest byte index in [31:24].
    task automatic load_mems();
        for (int w = 0; w < int'(IN_WORDS); w++) begin
            mem1[w] = {img[0][4*w], img[0][4*w+1], img[0][4*w+2], img[0][4*w+3]};
            mem2[w] = {img[1][4*w], img[1][4*w+1], img[1][4*w+2], img[1][4*w+3]};
        end
    endtask

    // Reference model: pool each 2x2 window with integer max, then pack.
    task automatic push_expected();
        logic [7:0] outp [OUT_DIM*OUT_DIM];
        wr_t        e;
        for (int ch = 0; ch < 2; ch++) begin
            for (int i = 0; i < int'(OUT_DIM); i++) begin
                for (int j = 0; j < int'(OUT_DIM); j++) begin
                    int m;
                    int v;
                    m = -1000;
                    for (int di = 0; di < 2; di++) begin
                        for (int dj = 0; dj < 2; dj++) begin
                            v = int'($signed(img[ch][(2*i+di)*int'(IMG_DIM) + 2*j + dj]));
                            if (v > m) m = v;
                        end
                    end
`ifdef POOL_RELU_EN
                    if (m < 0) m = 0;
`endif
                    outp[i*int'(OUT_DIM) + j] = 8'(m);
                end
            end
            for (int w = 0; w < int'(OUT_WORDS); w++) begin
                e = '0;
                e.addr = 32'(w);
                for (int l = 0; l < 4; l++) begin
                    if (4*w + l < int'(OUT_DIM*OUT_DIM)) begin
                        e.data[31-8*l -: 8] = outp[4*w + l];
                        e.be[3-l] = 1'b1;
                    end
                end
                if (ch == 0) q3.push_back(e);
                else         q4.push_back(e);
            end
        end
    endtask

    task automatic run_pass(input string name);
        int cyc;
        load_mems();
        push_expected();
        rd_exp = 0;
        start  = 1'b1;
        cyc    = 0;
        while (!finish && cyc < 600) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_finish"}, 72'(finish), 72'(1));
        check({name, "_latency_ok"}, 72'(cyc <= int'(MAX_LAT)), 72'(1));
        // start held high: no re-run, finish stays up
        repeat (4) begin
            @(negedge clk);
            check({name, "_finish_held"}, 72'(finish), 72'(1));
        end
        check({name, "_writes_drained"}, 72'(q3.size() + q4.size()), 72'(0));
        check({name, "_read_count"}, 72'(rd_exp), 72'(IN_WORDS));
        start = 1'b0;
        @(negedge clk);
        check({name, "_finish_drop"}, 72'(finish), 72'(0));
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs",
              72'({finish, M1_R_req, M2_R_req, M3_W_req, M4_W_req, M1_addr, M3_addr}), 72'(0));
        check("reset_data", 72'({M3_W_data, M4_W_data}), 72'(0));
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // All-zero maps
        for (int b = 0; b < int'(IN_BYTES); b++) begin
            img[0][b] = 8'h00;
            img[1][b] = 8'h00;
        end
        run_pass("zero");

        // Ramp on M1, constant -16 on M2
        for (int b = 0; b < int'(IN_BYTES); b++) begin
            img[0][b] = 8'(b % 100);
            img[1][b] = 8'hF0;
        end
        run_pass("ramp_f0");

        // Every window holds {80,7F,01,FF} in some order
        for (int b = 0; b < int'(IN_BYTES); b++) begin
            int pos;
            pos = ((b / int'(IMG_DIM)) % 2) * 2 + (b % 2);
            case (pos)
                0:       begin img[0][b] = 8'h80; img[1][b] = 8'hFF; end
                1:       begin img[0][b] = 8'h7F; img[1][b] = 8'h01; end
                2:       begin img[0][b] = 8'h01; img[1][b] = 8'h7F; end
                default: begin img[0][b] = 8'hFF; img[1][b] = 8'h80; end
            endcase
        end
        run_pass("quad");

        // Random maps
        for (int t = 0; t < 2; t++) begin
            for (int b = 0; b < int'(IN_BYTES); b++) begin
                img[0][b] = 8'($urandom);
                img[1][b] = 8'($urandom);
            end
            run_pass("random");
        end

        // Reset during row 6 POOL, then a clean pass
        for (int b = 0; b < int'(IN_BYTES); b++) begin
            img[0][b] = 8'($urandom);
            img[1][b] = 8'($urandom);
        end
        load_mems();
        push_expected();
        rd_exp = 0;
        start  = 1'b1;
        begin
            int cyc;
            cyc = 0;
            while (!(M1_R_req && M1_addr == 32'(13*6 + 12)) && cyc < 600) begin
                @(negedge clk);
                cyc++;
            end
            check("row6_fetch_seen", 72'(M1_addr), 72'(13*6 + 12));
        end
        repeat (4) @(negedge clk);
        #2;
        rst   = 1'b0;
        start = 1'b0;
        #1;
        check("midreset_outputs",
              72'({finish, M1_R_req, M2_R_req, M3_W_req, M4_W_req, M1_addr, M3_addr}), 72'(0));
        check("midreset_data", 72'({M3_W_data, M4_W_data}), 72'(0));
        q3.delete();
        q4.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rd_exp = 0;
        repeat (5) begin
            @(negedge clk);
            check("after_reset_quiet", 72'({M1_R_req, M2_R_req, M3_W_req, M4_W_req, finish}), 72'(0));
        end
        run_pass("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/relu_maxpool.md
Name: relu_maxpool

Overview:
- Stage directly downstream of the 3x3 convolution stage.
- Reads two 26x26 signed 8-bit feature maps, each packed 4 pixels per 32-bit word (169 words), from memories M1 and M2.
- Applies ReLU and 2x2/stride-2 max pooling to each map.
- Writes two 13x13 pooled maps, packed 4 per word (43 words), to M3 and M4 for the dense stage.

Parameters:
- IMG_DIM, 26, input map side; must be even, and 2*IMG_DIM must be divisible by 4.
- OUT_WORDS, 43, output words per channel = ceil((IMG_DIM/2)^2 / 4).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  level; begins a pass when high in IDLE
- finish  out  1  high in DONE; held until start goes low
- M1_R_req  out  1  channel-0 read request
- M1_addr  out  32  channel-0 word address
- M1_R_data  in  32  channel-0 read data, valid the cycle after M1_R_req
- M2_R_req, M2_addr, M2_R_data  same as M1_*, for channel 1
- M3_W_req  out  4  channel-0 byte enables; bit3 maps to [31:24]
- M3_addr  out  32  channel-0 output word address
- M3_W_data  out  32  channel-0 packed output
- M4_W_req, M4_addr, M4_W_data  same as M3_*, for channel 1

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: all outputs 0; FSM to IDLE; counters and packers cleared.
- Reset asserted mid-pass abandons the pass. No further reads or writes occur. The next pass restarts at row 0.
- Packing, both directions: the pixel with the lowest byte index sits in [31:24]. Byte index b = row*IMG_DIM + col, word = b>>2, lane = b&3.
- Row pair (2r, 2r+1) occupies exactly 13 aligned words starting at word 13r. One pooled output row needs one 13-word fetch per channel.
- FSM states:
  - IDLE: go to FETCH when start=1. Set r=0.
  - FETCH: M1/M2_R_req=1 with addr=13r+k for k=0..12, one word per cycle, back-to-back. Data arriving in the following cycle is stored in a 52-byte pair buffer per channel. The buffer is complete one cycle after the last request (14 cycles). Read requests are 0 in every cycle outside FETCH.
  - POOL: one column c=0..12 per cycle. Candidates are buf[2c], buf[2c+1], buf[26+2c], buf[27+2c], compared as signed. Output = max(0, signed max of candidates). Result goes to the packer's next lane. Then r++; go to FETCH if r<13, else FLUSH.
  - FLUSH: if the packer holds 1-3 lanes, write once with enables for the filled lanes only. Unfilled lanes carry 0. Go to DONE.
  - DONE: finish=1. When start=0, drop finish and go to IDLE.
- Packer: an output byte counter runs continuously across rows (0..168). When lane 3 fills, the next cycle drives W_req=4'hF, addr=counter>>2 and W_data for exactly one cycle. W_req=0 otherwise.
- For the 26x26 map, 42 full writes (addr 0..41) are followed by one flush write to addr 42 with W_req=4'b1000.
- Both channels run in lockstep and write in the same cycles to the same addresses.
- A packer write and the next row's FETCH may overlap; memories are independent.
- Arithmetic: comparisons are 8-bit signed; no widening or rounding.
- Latency: start-to-finish is at most 13*(14+13+2)+4 cycles.
- start is ignored outside IDLE and DONE.

Optional Feature:
- Macro POOL_RELU_EN.
- Defined: output = max(0, signed max), as above.
- Undefined: output = signed max with no clamp, so negative results pass through. The FSM, timing and writes are identical in both cases.

Decomposition:
- Shared package: state encoding (IDLE, FETCH, POOL, FLUSH, DONE), IMG_DIM, OUT_WORDS, and a byte-lane pack helper shared with the convolution stage.
- One natural sub-module, max4_relu: a combinational 4-input signed max with the optional clamp, instantiated once per channel.

Test Plan:
- All-zero M1/M2 -> 43 writes per channel: addr 0..41 with W_req=4'hF and data 0, then addr 42 with W_req=4'b1000 and data 0; finish=1.
- Ramp M1 byte b = b mod 100 (interpreted signed) -> M3 output (0,0) = 27. Check all 169 bytes against a reference model.
- M2 all 8'hF0 (-16) -> M4 all 0 with POOL_RELU_EN; all 8'hF0 without it.
- One quad per window = {8'h80, 8'h7F, 8'h01, 8'hFF} -> each output = 8'h7F.
- Reset asserted in row 6 POOL -> outputs 0 immediately; a new start completes a full correct pass from addr 0.
- start held high after finish -> finish stays 1, no re-run; start low -> finish drops next cycle.
